cnn_result_reader: RTL and testbench
====================================

// Module: cnn_result_reader
// PURPOSE
//  Consumer end of the 4x4 CNN cell array: watches the 16 parallel Y outputs of the
//  fourbyfour array after a run is started, waits until the outputs have settled
//  (or a cycle budget expires), freezes a snapshot and streams it out one cell per
//  beat over a valid/ready interface. It sits between the array and the host/readout logic.
// PARAMETERS
//  WIDTH          9    cell value width, signed fixed point {sign, 2^3..2^0, 2^-1..2^-4}
//  CELLS          16   number of cells read (4x4 array)
//  STABLE_CYCLES  4    consecutive unchanged cycles that define convergence (>=1)
//  MAX_CYCLES     255  settle-cycle budget before a forced capture (>=STABLE_CYCLES)
// PORTS
//  clk        in   1             system clock, all logic on rising edge
//  rst        in   1             synchronous reset, active-high
//  start      in   1             one-cycle pulse: begin monitoring a new run
//  y_flat     in   CELLS*WIDTH   Y1..Y16 packed, Y1 in bits [WIDTH-1:0], Yk at [(k)*WIDTH-1:(k-1)*WIDTH]
//  out_data   out  WIDTH         current cell value (signed)
//  out_idx    out  4             current cell index, 0 = Y1 .. 15 = Y16
//  out_valid  out  1             out_data/out_idx/out_last valid
//  out_ready  in   1             downstream accepts beat when out_valid & out_ready
//  out_last   out  1             high on the beat carrying index CELLS-1
//  busy       out  1             high in SETTLE and STREAM
//  done       out  1             one-cycle pulse in cycle after final beat accepted
//  timeout    out  1             sticky: last capture was forced by MAX_CYCLES
// BEHAVIOUR
//  Reset: state IDLE; out_data=0, out_idx=0, out_valid=0, out_last=0, busy=0, done=0,
//   timeout=0; prev/snapshot regs, stable_cnt, cycle_cnt cleared. rst wins over all inputs.
//  IDLE: start=1 -> SETTLE next cycle; prev<=y_flat, stable_cnt<=0, cycle_cnt<=0, timeout<=0.
//  SETTLE (each cycle): cycle_cnt++; if y_flat==prev (all CELLS*WIDTH bits) stable_cnt++,
//   else stable_cnt<=0 and prev<=y_flat.
//   - when the increment makes stable_cnt==STABLE_CYCLES: snapshot<=y_flat, -> STREAM.
//   - else when cycle_cnt reaches MAX_CYCLES: snapshot<=y_flat, timeout<=1, -> STREAM.
//   - both on same cycle: convergence wins, timeout stays 0.
//  STREAM: out_valid=1, out_data=snapshot[idx], out_idx=idx, out_last=(idx==CELLS-1).
//   Beat transfers on out_valid&out_ready; idx increments; outputs held stable while
//   out_ready=0 (no change of data/idx under stall). Transfer of idx CELLS-1 -> IDLE,
//   out_valid=0 next cycle, done=1 that cycle, idx<=0.
//  Changes on y_flat after capture do not affect streamed data.
//  start ignored while busy=1 (no restart mid-run); start in the cycle done=1 is accepted.
//  Minimum latency start->first out_valid: STABLE_CYCLES+1 cycles with constant y_flat.
//  timeout holds until next accepted start or rst. rst mid-SETTLE/STREAM aborts, no done.
//  No arithmetic on values: data passed bit-exact; counters saturate-free, sized ceil(log2)+1.
// TESTING
//  1 constant y_flat (Y6,Y7,Y10,Y11=9'h001, rest 0), start, out_ready=1 -> out_valid rises
//    5 cycles after start; 16 beats idx 0..15, data 1 at idx 5,6,9,10; last on idx 15; done; timeout=0.
//  2 y_flat toggles every 2 cycles forever, MAX_CYCLES=255 -> capture at cycle 255, timeout=1,
//    streamed values equal y_flat at capture cycle.
//  3 out_ready random 50% -> exactly 16 transfers, data/idx stable during every stall, no drop/dup.
//  4 y_flat changes once at cycle 2 then constant -> stable_cnt restarts, capture after cycle 6.
//  5 start pulsed during SETTLE and STREAM -> ignored; start with done=1 -> new run begins.
//  6 rst asserted mid-STREAM at idx 7 -> next cycle all outputs 0, IDLE, no done pulse.

Source files
------------

// File: rtl/cnn_result_reader.sv
// cnn_result_reader: waits for the 4x4 CNN array outputs to settle, snapshots them and streams one cell per beat.
module cnn_result_reader #(
  parameter int WIDTH         = 9,
  parameter int CELLS         = 16,
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_CYCLES    = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CELLS*WIDTH-1:0] y_flat,
  output logic [WIDTH-1:0]       out_data,
  output logic [3:0]             out_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout
);
  localparam int SW = $clog2(STABLE_CYCLES + 1) + 1;
  localparam int CW = $clog2(MAX_CYCLES + 1) + 1;
  typedef enum logic [1:0] {IDLE, SETTLE, STREAM} state_t;
  state_t r_state, w_next;
  logic [CELLS*WIDTH-1:0] r_prev, r_snap;
  logic [SW-1:0] r_stable, w_stable_nx;
  logic [CW-1:0] r_cycle, w_cycle_nx;
  logic [3:0] r_idx;
  logic r_done, r_timeout;
  logic w_go, w_same, w_conv, w_expire, w_xfer, w_last_xfer;
  assign w_go        = r_state == IDLE && start;
  assign w_same      = y_flat == r_prev;
  assign w_stable_nx = w_same ? r_stable + 1'b1 : '0;
  assign w_cycle_nx  = r_cycle + 1'b1;
  // convergence is tested first so a tie with the budget never flags timeout
  assign w_conv      = r_state == SETTLE && w_stable_nx == SW'(STABLE_CYCLES);
  assign w_expire    = r_state == SETTLE && !w_conv && w_cycle_nx == CW'(MAX_CYCLES);
  assign w_xfer      = r_state == STREAM && out_ready;
  assign w_last_xfer = w_xfer && r_idx == 4'(CELLS - 1);
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb
    w_next = w_go ? SETTLE : (w_conv || w_expire) ? STREAM : w_last_xfer ? IDLE : r_state;
  always_comb begin
    out_valid = r_state == STREAM;
    out_idx   = r_idx;
    out_data  = out_valid ? r_snap[r_idx*WIDTH +: WIDTH] : '0;
    out_last  = out_valid && r_idx == 4'(CELLS - 1);
    busy      = r_state != IDLE;
    done      = r_done;
    timeout   = r_timeout;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= '0;
      r_snap    <= '0;
      r_stable  <= '0;
      r_cycle   <= '0;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done <= w_last_xfer;
      if (w_go) begin
        r_prev    <= y_flat;
        r_stable  <= '0;
        r_cycle   <= '0;
        r_timeout <= 1'b0;
      end
      if (r_state == SETTLE) begin
        r_cycle  <= w_cycle_nx;
        r_stable <= w_stable_nx;
        if (!w_same) r_prev <= y_flat;
      end
      if (w_conv || w_expire) r_snap <= y_flat;
      if (w_expire) r_timeout <= 1'b1;
      if (w_xfer) r_idx <= w_last_xfer ? '0 : r_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_cnn_result_reader.sv
// tb_cnn_result_reader: randomized runs of the result reader checked against a sample-history reference model.
module tb_cnn_result_reader;
  localparam int W  = 9;
  localparam int N  = 16;
  localparam int ST = 4;
  localparam int MX = 255;
  logic clk = 0, rst = 1, start = 0, out_ready = 0;
  logic [N*W-1:0] y_flat = '0;
  logic [W-1:0] out_data;
  logic [3:0] out_idx;
  logic out_valid, out_last, busy, done, timeout;
  int errors = 0, checks = 0;
  logic [N*W-1:0] hist[$];
  logic [N*W-1:0] ya, yb, yc;
  always #5 clk = ~clk;
  cnn_result_reader #(.WIDTH(W), .CELLS(N), .STABLE_CYCLES(ST), .MAX_CYCLES(MX)) dut (
    .clk(clk), .rst(rst), .start(start), .y_flat(y_flat), .out_data(out_data),
    .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .timeout(timeout));
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [N*W-1:0] rnd_y();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction
  // value presented to the sampling edge with index k after the start edge
  function automatic logic [N*W-1:0] pattern_y(int mode, int k, logic [N*W-1:0] cur);
    if (mode == 0) return yc;
    if (mode == 1) return ((k / 2) % 2) ? ya : yb;
    if (mode == 2) return (k < 2) ? ya : yb;
    return ($urandom_range(3) == 0) ? rnd_y() : cur;
  endfunction
  // capture happens at the first edge whose sample closes a run of ST+1 identical samples,
  // otherwise at edge MX with timeout
  function automatic int model_capture(output bit to);
    to = 0;
    for (int k = 1; k < hist.size(); k++) begin
      bit eq = k >= ST;
      for (int j = k - ST; eq && j < k; j++) if (hist[j] !== hist[k]) eq = 0;
      if (eq) return k;
      if (k == MX) begin
        to = 1;
        return k;
      end
    end
    return -1;
  endfunction
  task automatic run_case(int mode, int rdy_pct, int rst_at);
    logic [N*W-1:0] cur, snap;
    logic [W-1:0] hd;
    logic [3:0] hi;
    int k, kc, beats, cyc;
    bit to, held;
    hist.delete();
    cur = pattern_y(mode, 0, rnd_y());
    y_flat = cur;
    start = 1;
    @(posedge clk);
    hist.push_back(y_flat);
    #1 start = 0;
    k = 0;
    while (!out_valid && k < 300) begin
      k++;
      cur = pattern_y(mode, k, cur);
      y_flat = cur;
      start = ($urandom_range(7) == 0);
      @(posedge clk);
      hist.push_back(y_flat);
      #1 start = 0;
    end
    kc = model_capture(to);
    check("latency", k, kc);
    check("timeout", timeout, to);
    check("busy", busy, 1);
    if (mode == 0) check("lat_min", k, ST);
    if (mode == 1) check("lat_max", k, MX);
    snap = (kc >= 0 && kc < hist.size()) ? hist[kc] : '0;
    beats = 0;
    cyc = 0;
    held = 0;
    while (beats < N && cyc < 400) begin
      if (rst_at == beats) begin
        rst = 1;
        out_ready = 1;
        @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        rst = 0;
        out_ready = 0;
        @(posedge clk);
        #1;
        check("rst_done2", done, 0);
        check("rst_valid2", out_valid, 0);
        return;
      end
      check("valid", out_valid, 1);
      if (held) begin
        check("stall_data", out_data, hd);
        check("stall_idx", out_idx, hi);
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      y_flat = rnd_y();
      start = ($urandom_range(7) == 0);
      if (out_ready) begin
        check("idx", out_idx, beats);
        check("data", out_data, snap[beats*W +: W]);
        check("last", out_last, beats == N - 1);
        beats++;
        held = 0;
      end else begin
        held = 1;
        hd = out_data;
        hi = out_idx;
      end
      @(posedge clk);
      #1 start = 0;
      cyc++;
    end
    out_ready = 0;
    check("beats", beats, N);
    check("done", done, 1);
    check("valid_end", out_valid, 0);
    check("busy_end", busy, 0);
    check("timeout_hold", timeout, to);
  endtask
  initial begin
    yc = '0;
    yc[5*W +: W] = 9'h001;
    yc[6*W +: W] = 9'h001;
    yc[9*W +: W] = 9'h001;
    yc[10*W +: W] = 9'h001;
    ya = rnd_y();
    yb = ~ya;
    repeat (2) @(posedge clk);
    #1;
    check("r_valid", out_valid, 0);
    check("r_data", out_data, 0);
    check("r_idx", out_idx, 0);
    check("r_last", out_last, 0);
    check("r_busy", busy, 0);
    check("r_done", done, 0);
    check("r_timeout", timeout, 0);
    rst = 0;
    @(posedge clk);
    #1;
    run_case(0, 100, -1);
    run_case(1, 100, -1);
    run_case(2, 100, -1);
    for (int i = 0; i < 3; i++) run_case(3, 50, -1);
    run_case(1, 50, -1);
    run_case(0, 50, 7);
    run_case(2, 50, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
